// File: rtl/preprocess_linebuf.sv
// 3x3 sliding-window generator over a rotating 3-row line buffer, raster-order input, valid/ready on both sides.
// Optional debug taps (wr_row, pos_col, pos_row) are enabled by defining PREPROC_DEBUG_EN.
module preprocess_linebuf #(
    parameter int DW       = 8,
    parameter int IMG_COLS = 540,
    parameter int IMG_ROWS = 960,
    parameter int COL_W    = $clog2(IMG_COLS),
    parameter int ROW_W    = $clog2(IMG_ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_en_i,
    input  logic [DW-1:0] data_i,
    output logic          fetch_rdy_o,
    input  logic          core_en_i,
    output logic          win_valid_o,
    output logic [DW-1:0] data_0_0_o,
    output logic [DW-1:0] data_0_1_o,
    output logic [DW-1:0] data_0_2_o,
    output logic [DW-1:0] data_1_0_o,
    output logic [DW-1:0] data_1_1_o,
    output logic [DW-1:0] data_1_2_o,
    output logic [DW-1:0] data_2_0_o,
    output logic [DW-1:0] data_2_1_o,
    output logic [DW-1:0] data_2_2_o,
    output logic          fetch_done_o,
    output logic          core_done_o,
    output logic          n_segment_up_o
`ifdef PREPROC_DEBUG_EN
    ,
    output logic [1:0]       cnt_buf_row,
    output logic [COL_W-1:0] cnt_buf_col,
    output logic [ROW_W-1:0] cnt_pos_row
`endif
);

    logic [COL_W-1:0] pos_col;
    logic [ROW_W-1:0] pos_row;
    logic [1:0]       wr_row;
    logic [1:0]       rd_old_row;
    logic [1:0]       rd_mid_row;

    logic [DW-1:0] line_mem [3][IMG_COLS];
    logic [DW-1:0] win      [3][3];

    logic win_valid_q;
    logic tag_last_col;
    logic tag_last_row;
    logic fetch_done_q;
    logic core_done_q;
    logic seg_up_q;

    logic accept;
    logic consume;
    logic col_last;
    logic row_last;
    logic qualify;

    assign fetch_rdy_o = ~win_valid_q | core_en_i;
    assign accept      = fetch_en_i & fetch_rdy_o;
    assign consume     = win_valid_q & core_en_i;
    assign col_last    = (pos_col == COL_W'(IMG_COLS - 1));
    assign row_last    = (pos_row == ROW_W'(IMG_ROWS - 1));
    assign qualify     = (pos_row >= ROW_W'(2)) && (pos_col >= COL_W'(2));

    // Rows two and one behind the write row, modulo 3.
    assign rd_old_row = (wr_row == 2'd2) ? 2'd0 : wr_row + 2'd1;
    assign rd_mid_row = (wr_row == 2'd0) ? 2'd2 : wr_row - 2'd1;

    always_ff @(posedge clk) begin
        if (accept) begin
            line_mem[wr_row][pos_col] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_col <= '0;
            pos_row <= '0;
            wr_row  <= 2'd0;
        end else if (accept) begin
            if (col_last) begin
                pos_col <= '0;
                if (row_last) begin
                    pos_row <= '0;
                    wr_row  <= 2'd0;
                end else begin
                    pos_row <= pos_row + ROW_W'(1);
                    wr_row  <= (wr_row == 2'd2) ? 2'd0 : wr_row + 2'd1;
                end
            end else begin
                pos_col <= pos_col + COL_W'(1);
            end
        end
    end

    // The window shifts on every accepted pixel so priming columns are already in place at col 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= line_mem[rd_old_row][pos_col];
            win[1][2] <= line_mem[rd_mid_row][pos_col];
            win[2][2] <= data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid_q  <= 1'b0;
            tag_last_col <= 1'b0;
            tag_last_row <= 1'b0;
        end else if (accept && qualify) begin
            win_valid_q  <= 1'b1;
            tag_last_col <= col_last;
            tag_last_row <= row_last;
        end else if (consume) begin
            win_valid_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_done_q <= 1'b0;
            core_done_q  <= 1'b0;
            seg_up_q     <= 1'b0;
        end else begin
            fetch_done_q <= accept & col_last & row_last;
            seg_up_q     <= consume & tag_last_col;
            core_done_q  <= consume & tag_last_col & tag_last_row;
        end
    end

    assign win_valid_o    = win_valid_q;
    assign fetch_done_o   = fetch_done_q;
    assign core_done_o    = core_done_q;
    assign n_segment_up_o = seg_up_q;

    assign data_0_0_o = win[0][0];
    assign data_0_1_o = win[0][1];
    assign data_0_2_o = win[0][2];
    assign data_1_0_o = win[1][0];
    assign data_1_1_o = win[1][1];
    assign data_1_2_o = win[1][2];
    assign data_2_0_o = win[2][0];
    assign data_2_1_o = win[2][1];
    assign data_2_2_o = win[2][2];

`ifdef PREPROC_DEBUG_EN
    assign cnt_buf_row = wr_row;
    assign cnt_buf_col = pos_col;
    assign cnt_pos_row = pos_row;
`endif

endmodule

// File: tb/tb_preprocess_linebuf.sv
// Scoreboard bench for preprocess_linebuf on an 8x4 image with pixel = row*16 + col.
// Define PREPROC_DEBUG_EN to also exercise the debug taps.
module tb_preprocess_linebuf;

    localparam int DW    = 8;
    localparam int COLS  = 8;
    localparam int ROWS  = 4;
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    typedef struct packed {
        logic [71:0] pix;
        logic        lc;
        logic        lr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          fetch_en;
    logic [DW-1:0] data_in;
    logic          fetch_rdy;
    logic          core_en;
    logic          win_valid;
    logic [DW-1:0] data_0_0, data_0_1, data_0_2;
    logic [DW-1:0] data_1_0, data_1_1, data_1_2;
    logic [DW-1:0] data_2_0, data_2_1, data_2_2;
    logic          fetch_done;
    logic          core_done;
    logic          n_seg_up;
`ifdef PREPROC_DEBUG_EN
    logic [1:0]       cnt_buf_row;
    logic [COL_W-1:0] cnt_buf_col;
    logic [ROW_W-1:0] cnt_pos_row;
`endif

    int n_checks = 0;
    int n_fails  = 0;
    int drv_row  = 0;
    int drv_col  = 0;
    int win_count   = 0;
    int seg_count   = 0;
    int cdone_count = 0;
    int fdone_count = 0;
    logic seg_pend  = 1'b0;
    logic core_pend = 1'b0;
    logic fd_pend   = 1'b0;
    exp_t sb_q[$];

    preprocess_linebuf #(.DW(DW), .IMG_COLS(COLS), .IMG_ROWS(ROWS)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en_i     (fetch_en),
        .data_i         (data_in),
        .fetch_rdy_o    (fetch_rdy),
        .core_en_i      (core_en),
        .win_valid_o    (win_valid),
        .data_0_0_o     (data_0_0),
        .data_0_1_o     (data_0_1),
        .data_0_2_o     (data_0_2),
        .data_1_0_o     (data_1_0),
        .data_1_1_o     (data_1_1),
        .data_1_2_o     (data_1_2),
        .data_2_0_o     (data_2_0),
        .data_2_1_o     (data_2_1),
        .data_2_2_o     (data_2_2),
        .fetch_done_o   (fetch_done),
        .core_done_o    (core_done),
        .n_segment_up_o (n_seg_up)
`ifdef PREPROC_DEBUG_EN
        ,
        .cnt_buf_row    (cnt_buf_row),
        .cnt_buf_col    (cnt_buf_col),
        .cnt_pos_row    (cnt_pos_row)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [71:0] expWindow(input int r, input int c);
        logic [71:0] p;
        p = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                p[(i*3+j)*8 +: 8] = 8'((r - 2 + i) * 16 + (c - 2 + j));
            end
        end
        return p;
    endfunction

    // Presents n pixels in raster order, waiting on fetch_rdy; pushes the expected window per qualifying pixel.
    task automatic applyStimulus(input int n);
        logic acc;
        logic qual;
        int   waited;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            fetch_en = 1'b1;
            data_in  = 8'(drv_row * 16 + drv_col);
            qual     = (drv_row >= 2) && (drv_col >= 2);
            acc      = 1'b0;
            waited   = 0;
            while (!acc && waited < 60) begin
                @(negedge clk);
                if (fetch_rdy) begin
                    acc = 1'b1;
                    if (qual) begin
                        e.pix = expWindow(drv_row, drv_col);
                        e.lc  = (drv_col == COLS - 1);
                        e.lr  = (drv_row == ROWS - 1);
                        sb_q.push_back(e);
                    end
                end
                @(posedge clk);
                #1;
                waited++;
            end
            if (!acc) begin
                checkOutput("accept_timeout", 72'(acc), 72'(1));
                fetch_en = 1'b0;
                return;
            end
            checkOutput("win_valid_after_accept", 72'(win_valid), 72'(qual));
            if (drv_col == COLS - 1) begin
                drv_col = 0;
                drv_row = (drv_row == ROWS - 1) ? 0 : drv_row + 1;
            end else begin
                drv_col++;
            end
        end
        fetch_en = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkReset();
        checkOutput("rst_win_valid", 72'(win_valid), 72'(0));
        checkOutput("rst_fetch_rdy", 72'(fetch_rdy), 72'(1));
        checkOutput("rst_fetch_done", 72'(fetch_done), 72'(0));
        checkOutput("rst_core_done", 72'(core_done), 72'(0));
        checkOutput("rst_n_seg_up", 72'(n_seg_up), 72'(0));
        checkOutput("rst_data_1_1", 72'(data_1_1), 72'(0));
        checkOutput("rst_data_2_2", 72'(data_2_2), 72'(0));
    endtask

    task automatic checkCounts(input int b_win, input int b_seg, input int b_cd, input int b_fd,
                               input int e_win, input int e_seg, input int e_cd, input int e_fd);
        checkOutput("window_count", 72'(win_count - b_win), 72'(e_win));
        checkOutput("n_seg_up_count", 72'(seg_count - b_seg), 72'(e_seg));
        checkOutput("core_done_count", 72'(cdone_count - b_cd), 72'(e_cd));
        checkOutput("fetch_done_count", 72'(fdone_count - b_fd), 72'(e_fd));
        checkOutput("scoreboard_empty", 72'(sb_q.size()), 72'(0));
    endtask

    // Monitor: pops on every consumed window and checks the pulses owed from the previous cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_q.delete();
            seg_pend  = 1'b0;
            core_pend = 1'b0;
            fd_pend   = 1'b0;
        end else begin
            checkOutput("n_segment_up_pulse", 72'(n_seg_up), 72'(seg_pend));
            checkOutput("core_done_pulse", 72'(core_done), 72'(core_pend));
            checkOutput("fetch_done_pulse", 72'(fetch_done), 72'(fd_pend));
            if (n_seg_up)   seg_count++;
            if (core_done)  cdone_count++;
            if (fetch_done) fdone_count++;
            seg_pend  = 1'b0;
            core_pend = 1'b0;
            fd_pend   = fetch_en && fetch_rdy && (drv_row == ROWS - 1) && (drv_col == COLS - 1);
            if (win_valid && core_en) begin
                win_count++;
                if (sb_q.size() == 0) begin
                    checkOutput("unexpected_window", 72'(win_valid), 72'(0));
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("window_data",
                        {data_2_2, data_2_1, data_2_0, data_1_2, data_1_1, data_1_0,
                         data_0_2, data_0_1, data_0_0}, e.pix);
                    seg_pend  = e.lc;
                    core_pend = e.lc & e.lr;
                end
            end
        end
    end

    initial begin
        int b_win, b_seg, b_cd, b_fd;
        rst      = 1'b1;
        fetch_en = 1'b0;
        data_in  = '0;
        core_en  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkReset();
        rst = 1'b0;

        $display("[TB] single frame, free-running core");
        b_win = win_count; b_seg = seg_count; b_cd = cdone_count; b_fd = fdone_count;
        applyStimulus(32);
        waitCycles(4);
        checkCounts(b_win, b_seg, b_cd, b_fd, 12, 2, 1, 1);

        $display("[TB] core backpressure on the first window");
        core_en = 1'b0;
        b_win = win_count; b_seg = seg_count; b_cd = cdone_count; b_fd = fdone_count;
        fork
            applyStimulus(32);
            begin
                int w;
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!win_valid && w < 200);
                checkOutput("stall_window_seen", 72'(win_valid), 72'(1));
                for (int s = 0; s < 5; s++) begin
                    checkOutput("stall_fetch_rdy", 72'(fetch_rdy), 72'(0));
                    checkOutput("stall_hold_0_0", 72'(data_0_0), 72'(8'h00));
                    checkOutput("stall_hold_1_1", 72'(data_1_1), 72'(8'h11));
                    checkOutput("stall_hold_2_2", 72'(data_2_2), 72'(8'h22));
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                core_en = 1'b1;
            end
        join
        waitCycles(4);
        checkCounts(b_win, b_seg, b_cd, b_fd, 12, 2, 1, 1);

        $display("[TB] two back-to-back frames");
        b_win = win_count; b_seg = seg_count; b_cd = cdone_count; b_fd = fdone_count;
        applyStimulus(64);
        waitCycles(4);
        checkCounts(b_win, b_seg, b_cd, b_fd, 24, 4, 2, 2);

        $display("[TB] reset mid-frame after pixel 0x15");
        applyStimulus(14);
        rst = 1'b1;
        #1;
        checkReset();
        @(posedge clk);
        #1;
        rst     = 1'b0;
        drv_row = 0;
        drv_col = 0;
        b_win = win_count; b_seg = seg_count; b_cd = cdone_count; b_fd = fdone_count;
        applyStimulus(32);
        waitCycles(4);
        checkCounts(b_win, b_seg, b_cd, b_fd, 12, 2, 1, 1);

`ifdef PREPROC_DEBUG_EN
        $display("[TB] debug taps after pixel 0x25");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        drv_row = 0;
        drv_col = 0;
        applyStimulus(22);
        checkOutput("dbg_cnt_buf_row", 72'(cnt_buf_row), 72'(2));
        checkOutput("dbg_cnt_buf_col", 72'(cnt_buf_col), 72'(6));
        checkOutput("dbg_cnt_pos_row", 72'(cnt_pos_row), 72'(2));
        waitCycles(4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
